// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, ten host-driven
// bits on device clock falling edges, then ACK check and wait for idle lines.
module ps2_command_out #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] command,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state     | meaning
  // IDLE      | lines released, waiting for send
  // INHIBIT   | host holds clock low; data pulled low in the final cycle
  // REQ       | clock released, start bit on data, waiting for first device edge
  // DATA      | driving data bits, parity and stop on device falling edges
  // ACK       | stop bit released, waiting for edge 11 to sample device ACK
  // WAIT_IDLE | ACK seen, waiting for both lines high
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} state_t;

  localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] INH_LOAD   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LOAD  = CW'(XFER_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [7:0]    cmd;
  logic          parity;

  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic clk_fall;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      cmd        <= '0;
      parity     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          // busy is still high in the done/error cycle, so a send there is dropped
          if (send && !busy) begin
            cmd        <= command;
            parity     <= ~^command;
            timer      <= INH_LOAD;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= (INHIBIT_CYCLES == 1);
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer == '0) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            timer      <= START_LOAD;
            state      <= REQ;
          end else begin
            timer <= timer - 1'b1;
            if (timer == CW'(1)) ps2_dat_oe <= 1'b1;
          end
        end
        REQ: begin
          if (clk_fall) begin
            bit_cnt    <= 4'd1;
            ps2_dat_oe <= ~cmd[0];
            timer      <= XFER_LOAD;
            state      <= DATA;
          end else if (timer == '0) begin
            error      <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            error      <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer - 1'b1;
            if (clk_fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt < 4'd8) begin
                ps2_dat_oe <= ~cmd[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                ps2_dat_oe <= ~parity;
              end else begin
                ps2_dat_oe <= 1'b0;
                state      <= ACK;
              end
            end
          end
        end
        ACK: begin
          if (timer == '0) begin
            error      <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer - 1'b1;
            if (clk_fall) begin
              if (!dat_sync) begin
                bit_cnt <= bit_cnt + 4'd1;
                state   <= WAIT_IDLE;
              end else begin
                error      <= 1'b1;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                state      <= IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (timer == '0) begin
            error      <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= IDLE;
          end else if (clk_sync && dat_sync) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Bench for ps2_command_out: a behavioural PS/2 device clocks the transfer while a
// scoreboard compares sampled data bits and done/error pulses against hand tables.
`timescale 1ns/1ps
module tb_ps2_command_out;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       send = 1'b0;
  logic [7:0] command = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_line, ps2_dat_line;
  logic       clk_oe, dat_oe, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_bits[$];
  int obs_bits[$];
  int exp_res[$];   // 1 = done, 2 = error

  assign ps2_clk_line = dev_clk & ~clk_oe;
  assign ps2_dat_line = dev_dat & ~dat_oe;

  ps2_command_out #(
    .INHIBIT_CYCLES(10),
    .START_TIMEOUT (200),
    .XFER_TIMEOUT  (2000)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .send      (send),
    .command   (command),
    .PS2_CLK   (ps2_clk_line),
    .PS2_DAT   (ps2_dat_line),
    .ps2_clk_oe(clk_oe),
    .ps2_dat_oe(dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: drains sampled bits and result pulses against the expectation queues.
  initial begin
    int o;
    forever begin
      @(negedge clk);
      while (obs_bits.size() > 0) begin
        o = obs_bits.pop_front();
        if (exp_bits.size() == 0) chk("unexpected_bit", o, -1);
        else chk("dat_oe_bit", o, exp_bits.pop_front());
      end
      if (done || error) begin
        chk("done_error_exclusive", int'(done && error), 0);
        if (exp_res.size() == 0) chk("unexpected_pulse", done ? 1 : 2, 0);
        else chk("result", done ? 1 : 2, exp_res.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [0:9] seq, input int n, input int res);
    for (int i = 0; i < n; i++) exp_bits.push_back(int'(seq[i]));
    if (res != 0) exp_res.push_back(res);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    send = 1'b1;
    command = c;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Device model: 40-cycle clock period, samples host data while clock is high.
  task automatic device(input bit ack, input int abort_edge);
    int t = 0;
    while (!(clk_oe == 1'b0 && dat_oe == 1'b1 && busy == 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", int'(t < 1000), 1);
    if (t >= 1000) return;
    repeat (10) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      dev_clk = 1'b0;
      if (e == abort_edge) return;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (e <= 10) obs_bits.push_back(int'(dat_oe));
      if (e == 10 && ack) dev_dat = 1'b0;
      if (e == 11) dev_dat = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("returned_idle", int'(t < 500), 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int inh, first, req;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", int'(clk_oe), 0);
    chk("rst_dat_oe", int'(dat_oe), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_error",  int'(error), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED acked
    push_exp(10'b0100100000, 10, 1);
    fork
      device(1'b1, 0);
      send_cmd(8'hED);
    join
    wait_idle();

    // 0x01: parity bit 0, 0xFF: parity bit 1
    push_exp(10'b0111111110, 10, 1);
    fork
      device(1'b1, 0);
      send_cmd(8'h01);
    join
    wait_idle();
    push_exp(10'b0000000000, 10, 1);
    fork
      device(1'b1, 0);
      send_cmd(8'hFF);
    join
    wait_idle();

    // Silent device: inhibit length, then start timeout
    exp_res.push_back(2);
    send_cmd(8'h3C);
    inh = 0;
    first = -1;
    while (clk_oe && inh < 100) begin
      if (dat_oe && first < 0) first = inh;
      inh++;
      @(negedge clk);
    end
    chk("inhibit_cycles", inh, 10);
    chk("inhibit_dat_first", first, 9);
    req = 0;
    while (!error && req < 1000) begin
      req++;
      @(negedge clk);
    end
    chk("start_timeout_cycles", req, 200);
    chk("err_clk_oe", int'(clk_oe), 0);
    chk("err_dat_oe", int'(dat_oe), 0);
    chk("err_busy_same_cycle", int'(busy), 1);
    @(negedge clk);
    chk("busy_after_error", int'(busy), 0);
    repeat (5) @(negedge clk);

    // NACK
    push_exp(10'b1010101000, 10, 2);
    fork
      device(1'b0, 0);
      send_cmd(8'hAA);
    join
    wait_idle();

    // Second send while busy is ignored
    push_exp(10'b0100100000, 10, 1);
    fork
      device(1'b1, 0);
      send_cmd(8'hED);
      begin
        repeat (150) @(negedge clk);
        send_cmd(8'h00);
      end
    join
    wait_idle();

    // Reset at edge 5, then a clean 0xF4
    push_exp(10'b0100100000, 4, 0);
    fork
      device(1'b1, 5);
      send_cmd(8'hED);
    join
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_oe", int'(clk_oe), 0);
    chk("midrst_dat_oe", int'(dat_oe), 0);
    chk("midrst_busy",   int'(busy), 0);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_done",  int'(done), 0);
    chk("midrst_error", int'(error), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push_exp(10'b1101000010, 10, 1);
    fork
      device(1'b1, 0);
      send_cmd(8'hF4);
    join
    wait_idle();

    repeat (10) @(negedge clk);
    chk("exp_bits_drained", exp_bits.size(), 0);
    chk("exp_res_drained", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_command_out.md
PS2_COMMAND_OUT -- requirements
Module: ps2_command_out

Interface
REQ-001 SHALL provide parameter INHIBIT_CYCLES, default 6000, meaning CLOCK_50 cycles PS2_CLK is held low before request-to-send (120 us).
REQ-002 SHALL provide parameter START_TIMEOUT, default 750000, meaning max cycles from clock release to first device falling edge (15 ms).
REQ-003 SHALL provide parameter XFER_TIMEOUT, default 100000, meaning max cycles from first falling edge to line-idle after ACK (2 ms).
REQ-004 CLOCK_50  input  1  sole system clock, 50 MHz, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 send  input  1  one-cycle request to transmit command.
REQ-007 command  input  8  byte to transmit; sampled only in the cycle send is accepted.
REQ-008 PS2_CLK  input  1  PS/2 clock line as read from the pad.
REQ-009 PS2_DAT  input  1  PS/2 data line as read from the pad.
REQ-010 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain), 0 = release.
REQ-011 ps2_dat_oe  output  1  1 = pull PS/2 data low (open-drain), 0 = release.
REQ-012 busy  output  1  high from accepted send until done/error cycle inclusive.
REQ-013 done  output  1  one-cycle pulse: device ACKed and lines returned idle.
REQ-014 error  output  1  one-cycle pulse: NACK or timeout; never coincident with done.

Function
REQ-015 PS2_CLK and PS2_DAT SHALL pass through a 2-flop synchroniser; falling edge = synced previous 1, current 0.
REQ-016 States SHALL be IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe 0, busy 0; send=1 latches command, computes odd parity, loads counter, -> INHIBIT next cycle.
REQ-018 send while busy=1 SHALL be ignored; command register unchanged.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_dat_oe asserts in the final INHIBIT cycle; -> REQ.
REQ-020 REQ: ps2_clk_oe=0, ps2_dat_oe=1 (start bit); first falling edge -> DATA with edge count 1; no edge within START_TIMEOUT cycles -> error.
REQ-021 Transfer timer SHALL start at first falling edge and cover DATA, ACK, WAIT_IDLE; expiry at XFER_TIMEOUT -> error.
REQ-022 On falling edge n=1..8, ps2_dat_oe SHALL become ~command[n-1] (LSB first) next cycle.
REQ-023 Edge 9: ps2_dat_oe = ~parity, parity = 1 when command has even count of ones.
REQ-024 Edge 10: ps2_dat_oe = 0 (stop bit, line released); -> ACK.
REQ-025 ACK: at edge 11, synced PS2_DAT=0 -> WAIT_IDLE; PS2_DAT=1 -> error (NACK).
REQ-026 WAIT_IDLE: when synced PS2_CLK=1 and PS2_DAT=1 -> done pulse, -> IDLE.
REQ-027 Any error: both oe 0 in the same cycle error is high, -> IDLE; busy drops the cycle after.
REQ-028 Outputs ps2_clk_oe, ps2_dat_oe, busy, done, error SHALL be registered (no combinational path from PS2_* inputs).
REQ-029 Counters SHALL be sized ceil(log2(max param + 1)) bits; no wrap before timeout compare.
REQ-030 Falling edge arriving in INHIBIT SHALL be ignored (host owns clock).

Reset
REQ-031 reset_n=0 SHALL asynchronously force state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, counters 0, synchroniser flops 1.
REQ-032 Reset mid-transfer SHALL release both lines immediately with no done or error pulse; operation resumes on first send after reset_n=1.

Verification (INHIBIT_CYCLES=10, START_TIMEOUT=200, XFER_TIMEOUT=2000, device model clock period 40 cycles)
REQ-033 send command=0xED, model ACKs -> dat_oe sequence after start: 0,1,0,0,1,0,0,0, parity dat_oe=0 (parity 1), stop released, done pulse once, error 0.
REQ-034 send 0x01 -> parity bit 0 (dat_oe=1 at edge 9); send 0xFF -> parity 1; both complete with done.
REQ-035 model never clocks -> error pulse exactly 200 cycles after REQ entry, both oe 0, busy 0 next cycle.
REQ-036 model leaves DAT high at edge 11 -> error pulse, no done.
REQ-037 second send pulses during transfer of 0xED -> ignored; transmitted bits still match 0xED; exactly one done.
REQ-038 reset_n low at edge 5 of transfer -> both oe 0 asynchronously, busy 0, no pulses; subsequent send 0xF4 completes with done.
